// File: rtl/bsg_fifo_pkg.sv
// Shared definitions for the small 1r1w FIFO: pointer-width helper and flag bundle.
package bsg_fifo_pkg;

    // A single-entry FIFO still needs a 1-bit pointer to keep widths legal.
    function automatic int lg_els(int els);
        return (els == 1) ? 1 : $clog2(els);
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
    } fifo_flags_s;

endpackage

// File: rtl/bsg_mem_1r1w_synth.sv
// Synthesizable 1-write/1-read register-file memory; asynchronous read, no contents reset.
module bsg_mem_1r1w_synth #(
    parameter int width_p                = 9,
    parameter int els_p                  = 2,
    parameter int read_write_same_addr_p = 0,
    parameter int harden_p               = 0,
    parameter int addr_width_lp          = bsg_fifo_pkg::lg_els(els_p)
) (
    input  logic                     w_clk_i,
    input  logic                     w_reset_i,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic                     r_v_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] mem [els_p];

    // Reset, read-enable and the configuration knobs carry no function in this flop-based model.
    logic unused_sink;
    assign unused_sink = &{1'b0, w_reset_i, r_v_i,
                           (read_write_same_addr_p != 0), (harden_p != 0)};

    always_ff @(posedge w_clk_i) begin
        if (w_v_i) begin
            mem[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem[r_addr_i];

endmodule

// File: rtl/bsg_fifo_1r1w_small_ctrl.sv
// Small single-clock FIFO controller: pointers, full/empty flags, valid/ready in and valid/yumi out.
// Define FIFO_EMPTY_BYPASS_EN to let a word flow straight through when the FIFO is empty.
module bsg_fifo_1r1w_small_ctrl
    import bsg_fifo_pkg::*;
#(
    parameter int width_p = 9,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int lg_els_lp = lg_els(els_p);

    logic [lg_els_lp-1:0] wptr_r, rptr_r;
    logic [lg_els_lp-1:0] wptr_nxt, rptr_nxt;
    fifo_flags_s          flags_r;
    logic                 enq, deq;
    logic [width_p-1:0]   mem_data;

    assign wptr_nxt = wptr_r + 1'b1;
    assign rptr_nxt = rptr_r + 1'b1;

    // Never looks at yumi_i, so a full FIFO cannot accept in the same cycle it drains.
    assign ready_o = ~flags_r.full & ~reset_i;

`ifdef FIFO_EMPTY_BYPASS_EN
    logic bypass;
    assign v_o    = ~flags_r.empty | (v_i & ready_o);
    assign data_o = flags_r.empty ? data_i : mem_data;
    // An empty FIFO handing the incoming word straight to the consumer stores nothing.
    assign bypass = flags_r.empty & v_i & ready_o & yumi_i;
    assign enq    = v_i & ready_o & ~bypass;
    assign deq    = yumi_i & v_o & ~bypass;
`else
    assign v_o    = ~flags_r.empty;
    assign data_o = mem_data;
    assign enq    = v_i & ready_o;
    assign deq    = yumi_i & v_o;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_r        <= '0;
            rptr_r        <= '0;
            flags_r.full  <= 1'b0;
            flags_r.empty <= 1'b1;
        end else begin
            if (enq) wptr_r <= wptr_nxt;
            if (deq) rptr_r <= rptr_nxt;
            if (enq && !deq) begin
                flags_r.empty <= 1'b0;
                flags_r.full  <= (wptr_nxt == rptr_r);
            end else if (deq && !enq) begin
                flags_r.full  <= 1'b0;
                flags_r.empty <= (rptr_nxt == wptr_r);
            end
        end
    end

    bsg_mem_1r1w_synth #(
        .width_p               (width_p),
        .els_p                 (els_p),
        .read_write_same_addr_p(0),
        .harden_p              (0)
    ) mem (
        .w_clk_i  (clk_i),
        .w_reset_i(reset_i),
        .w_v_i    (enq),
        .w_addr_i (wptr_r),
        .w_data_i (data_i),
        .r_v_i    (v_o),
        .r_addr_i (rptr_r),
        .r_data_o (mem_data)
    );

endmodule
